frame_buffer_writer: RTL and testbench

- Write side of the LED cube frame memory: accepts a byte stream of cube frames and fills a double-buffered 64-byte frame store.
- Serves the frame driver's read port (`addr` → `data_to_latch`) from the active bank.
- Swaps banks only at the driver's frame boundary (`done`), so a frame is never torn mid-scan.

---
 rtl/led_cube_pkg.sv | 26 ++
 rtl/frame_bank.sv | 31 +++
 rtl/frame_buffer_writer.sv | 120 ++++++++++++
 tb/tb_frame_buffer_writer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/led_cube_pkg.sv
// Shared types and constants for the LED cube frame path.
// Frame addresses are {layer, latch}, three bits each.
package led_cube_pkg;

  localparam int DATA_W      = 8;
  localparam int ADDR_W      = 6;
  localparam int FRAME_BYTES = 64;

  typedef enum logic {
    FILL = 1'b0,
    FULL = 1'b1
  } writer_state_t;

  function automatic logic [2:0] addr_layer(
    input logic [ADDR_W-1:0] a
  );
    return a[5:3];
  endfunction

  function automatic logic [2:0] addr_latch(
    input logic [ADDR_W-1:0] a
  );
    return a[2:0];
  endfunction

endpackage

// File: rtl/frame_bank.sv
// One frame of latch bytes: async-cleared register array,
// one synchronous write port, one combinational read port.
module frame_bank #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 6,
  parameter int DEPTH  = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/frame_buffer_writer.sv
// Double-buffered cube frame store: stream fills the back bank,
// driver reads the front bank, swap only on frame_done.
module frame_buffer_writer #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 6,
  parameter int FRAME_BYTES = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sof,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              frame_done,
  output logic              frame_pending,
  output logic              swap,
  output logic              active_bank,
  output logic              sof_err
);

  import led_cube_pkg::*;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_BYTES - 1);

  writer_state_t     r_state;
  writer_state_t     w_state_nxt;
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] w_wr_ptr_nxt;
  logic [ADDR_W-1:0] w_waddr;
  logic              r_active_bank;
  logic              r_swap;
  logic              r_sof_err;
  logic              w_accept;
  logic              w_do_swap;
  logic              w_sof_err;
  logic [DATA_W-1:0] w_rd0;
  logic [DATA_W-1:0] w_rd1;

  always_comb begin
    w_state_nxt  = r_state;
    w_wr_ptr_nxt = r_wr_ptr;
    w_waddr      = r_wr_ptr;
    w_accept     = 1'b0;
    w_do_swap    = 1'b0;
    w_sof_err    = 1'b0;
    unique case (r_state)
      FILL: begin
        w_accept = in_valid;
        if (in_sof) w_waddr = '0;
        if (w_accept) begin
          w_wr_ptr_nxt = w_waddr + 1'b1;
          w_sof_err    = in_sof && (r_wr_ptr != '0);
          if (w_waddr == LAST) w_state_nxt = FULL;
        end
      end
      FULL: begin
        if (frame_done) begin
          w_do_swap   = 1'b1;
          w_state_nxt = FILL;
        end
      end
      default: w_state_nxt = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= FILL;
      r_wr_ptr      <= '0;
      r_active_bank <= 1'b0;
      r_swap        <= 1'b0;
      r_sof_err     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wr_ptr      <= w_wr_ptr_nxt;
      r_active_bank <= r_active_bank ^ w_do_swap;
      r_swap        <= w_do_swap;
      r_sof_err     <= w_sof_err;
    end
  end

  // Writes always land in the bank the driver is not reading.
  frame_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FRAME_BYTES)
  ) u_bank0 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept && r_active_bank),
    .i_waddr (w_waddr),
    .i_wdata (in_data),
    .i_raddr (rd_addr),
    .o_rdata (w_rd0)
  );

  frame_bank #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (FRAME_BYTES)
  ) u_bank1 (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_we    (w_accept && !r_active_bank),
    .i_waddr (w_waddr),
    .i_wdata (in_data),
    .i_raddr (rd_addr),
    .o_rdata (w_rd1)
  );

  assign rd_data       = r_active_bank ? w_rd1 : w_rd0;
  assign in_ready      = (r_state == FILL);
  assign frame_pending = (r_state == FULL);
  assign swap          = r_swap;
  assign sof_err       = r_sof_err;
  assign active_bank   = r_active_bank;

endmodule

// File: tb/tb_frame_buffer_writer.sv
// Bench for frame_buffer_writer: directed tables, corner
// sequences and random traffic against a frame-queue model.
module tb_frame_buffer_writer;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_sof;
  logic       in_ready;
  logic [5:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_done;
  logic       frame_pending;
  logic       swap;
  logic       active_bank;
  logic       sof_err;

  int n_cmp = 0;
  int n_err = 0;

  frame_buffer_writer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_data       (in_data),
    .in_sof        (in_sof),
    .in_ready      (in_ready),
    .rd_addr       (rd_addr),
    .rd_data       (rd_data),
    .frame_done    (frame_done),
    .frame_pending (frame_pending),
    .swap          (swap),
    .active_bank   (active_bank),
    .sof_err       (sof_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: shown frame, bytes of the frame being collected.
  logic [7:0] m_shown [64];
  logic [7:0] m_q [$];
  logic       m_act;
  logic       m_swap;
  logic       m_sof_err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    foreach (m_shown[i]) m_shown[i] = 8'h00;
    m_q.delete();
    m_act     = 1'b0;
    m_swap    = 1'b0;
    m_sof_err = 1'b0;
  endtask

  task automatic model_edge(input logic v, input logic [7:0] d,
                            input logic s, input logic dn);
    bit pend;
    bit acc;
    pend      = (m_q.size() == 64);
    acc       = v && !pend;
    m_swap    = pend && dn;
    m_sof_err = acc && s && (m_q.size() != 0);
    if (pend && dn) begin
      foreach (m_shown[i]) m_shown[i] = m_q[i];
      m_q.delete();
      m_act = !m_act;
    end else if (acc) begin
      if (s) m_q.delete();
      m_q.push_back(d);
    end
  endtask

  task automatic check_model();
    chk("in_ready", 32'(in_ready), 32'(m_q.size() != 64));
    chk("frame_pending", 32'(frame_pending), 32'(m_q.size() == 64));
    chk("swap", 32'(swap), 32'(m_swap));
    chk("sof_err", 32'(sof_err), 32'(m_sof_err));
    chk("active_bank", 32'(active_bank), 32'(m_act));
    chk("rd_data", 32'(rd_data), 32'(m_shown[rd_addr]));
  endtask

  // Inputs are driven 1 time unit after a rising edge.
  task automatic tick(input logic v, input logic [7:0] d,
                      input logic s, input logic dn,
                      input logic [5:0] a);
    in_valid   = v;
    in_data    = d;
    in_sof     = s;
    frame_done = dn;
    rd_addr    = a;
    @(posedge clk);
    model_edge(v, d, s, dn);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       s;
    logic       dn;
    logic [5:0] a;
    logic       e_ready;
    logic       e_pend;
    logic       e_swap;
    logic       e_bank;
    logic [7:0] e_rd;
  } vec_t;

  vec_t tbl [3];

  initial begin
    tbl[0] = '{1'b1, 8'hC3, 1'b0, 1'b0, 6'd5,
               1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    tbl[1] = '{1'b1, 8'hC3, 1'b0, 1'b1, 6'd5,
               1'b1, 1'b0, 1'b1, 1'b1, 8'h05};
    tbl[2] = '{1'b1, 8'hC3, 1'b0, 1'b0, 6'd63,
               1'b1, 1'b0, 1'b0, 1'b1, 8'h3F};

    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_data    = 8'h00;
    in_sof     = 1'b0;
    frame_done = 1'b0;
    rd_addr    = 6'd0;
    model_reset();
    #1;
    chk("rst in_ready", 32'(in_ready), 32'd1);
    chk("rst frame_pending", 32'(frame_pending), 32'd0);
    chk("rst active_bank", 32'(active_bank), 32'd0);
    chk("rst swap", 32'(swap), 32'd0);
    chk("rst sof_err", 32'(sof_err), 32'd0);
    for (int i = 0; i < 64; i++) begin
      rd_addr = 6'(i);
      #1;
      chk("rst rd_data", 32'(rd_data), 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Full frame, byte k = k.
    for (int k = 0; k < 64; k++) tick(1'b1, 8'(k), k == 0, 1'b0, 6'd5);
    chk("full in_ready", 32'(in_ready), 32'd0);
    chk("full frame_pending", 32'(frame_pending), 32'd1);
    chk("full rd old bank", 32'(rd_data), 32'd0);

    // Backpressure then swap; held C3 lands at address 0.
    foreach (tbl[i]) begin
      tick(tbl[i].v, tbl[i].d, tbl[i].s, tbl[i].dn, tbl[i].a);
      chk("tbl in_ready", 32'(in_ready), 32'(tbl[i].e_ready));
      chk("tbl frame_pending", 32'(frame_pending), 32'(tbl[i].e_pend));
      chk("tbl swap", 32'(swap), 32'(tbl[i].e_swap));
      chk("tbl active_bank", 32'(active_bank), 32'(tbl[i].e_bank));
      chk("tbl rd_data", 32'(rd_data), 32'(tbl[i].e_rd));
    end
    for (int k = 1; k < 64; k++) tick(1'b1, 8'(k + 64), 1'b0, 1'b0, 6'd0);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 6'd0);
    chk("bp swap", 32'(swap), 32'd1);
    chk("bp rd addr0", 32'(rd_data), 32'hC3);
    chk("bp active_bank", 32'(active_bank), 32'd0);

    // Mid-frame sof, done in FILL, done coincident with byte 63.
    for (int k = 0; k < 10; k++) tick(1'b1, 8'(k + 16), k == 0, 1'b0, 6'd0);
    tick(1'b1, 8'hAA, 1'b1, 1'b0, 6'd0);
    chk("sof_err pulse", 32'(sof_err), 32'd1);
    for (int k = 1; k < 64; k++) begin
      tick(1'b1, 8'(k + 128), 1'b0, (k == 20) || (k == 63), 6'd0);
      if (k == 21) chk("done in fill", 32'(swap), 32'd0);
    end
    chk("done@63 swap", 32'(swap), 32'd0);
    chk("done@63 pending", 32'(frame_pending), 32'd1);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 6'd0);
    chk("sof frame swap", 32'(swap), 32'd1);
    chk("sof frame addr0", 32'(rd_data), 32'hAA);

    // Asynchronous reset mid-fill.
    for (int k = 0; k < 30; k++) tick(1'b1, 8'(k + 7), k == 0, 1'b0, 6'd0);
    rst_n = 1'b0;
    #2;
    model_reset();
    check_model();
    chk("async rd_data", 32'(rd_data), 32'd0);
    chk("async in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 0; k < 64; k++) tick(1'b1, 8'(255 - k), k == 0, 1'b0, 6'd9);
    tick(1'b0, 8'h00, 1'b0, 1'b1, 6'd9);
    chk("post-rst swap", 32'(swap), 32'd1);
    chk("post-rst rd", 32'(rd_data), 32'(255 - 9));

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      tick($urandom_range(0, 9) < 7, 8'($urandom),
           $urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0,
           6'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
